alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
Sequencer that executes a full WIDTH-bit ALU operation (AND, OR, ADD, SUB, SLT) on one 1-bit ALU slice, one bit per clock, LSB first. Carry is chained through a register, and the SLT set bit is fed back to bit 0 at the end. Used as the area-minimal ALU option beside the parallel ripple ALU. Requesters use a start/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
IDX_W, $clog2(WIDTH), width of the bit-index counter

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request; sampled only in IDLE
signal  input  6  function code: AND=36, OR=37, ADD=32, SUB=34, SLT=42
dataA  input  WIDTH  operand A
dataB  input  WIDTH  operand B
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result is final
err  output  1  valid with done; 1 = illegal function code
result  output  WIDTH  final result; held until the next accepted start
cout  output  1  carry-out of MSB (ADD/SUB/SLT); 0 for AND/OR
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB); 0 for AND/OR
zero  output  1  result == 0; valid with done and held with result

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, err=0, result=0, cout=0, ovf=0, zero=1. Internal operand/carry/index registers are cleared.
- Reset mid-operation aborts the operation. No done is produced.
- States: IDLE, RUN.
- IDLE, start=1, legal code:
  - Latch dataA, dataB, signal. idx=0.
  - carry=1 for SUB/SLT (B inverted in the slice, +1), else 0.
  - Go to RUN; busy=1.
- IDLE, start=1, illegal code:
  - Stay IDLE. Next cycle: done=1, err=1, result=0, zero=1, cout=0, ovf=0.
- RUN, each edge processes bit idx:
  - Slice output is written to an internal shift/accumulate register at position idx.
  - carry <= slice carry-out. The carry into bit idx is kept for the MSB overflow computation.
  - idx increments.
- RUN, edge with idx==WIDTH-1:
  - Finalize, go to IDLE, busy=0, done=1 for exactly one cycle, err=0.
  - AND/OR/ADD/SUB: result = accumulated bits.
  - SLT: set = sum[MSB] XOR ovf (signed-correct); result = {WIDTH-1 zeros, set}.
  - cout and ovf are updated for ADD/SUB/SLT and cleared for AND/OR. zero is computed from the final result.
- Latency: start accepted at edge E0 -> done high in the cycle following edge E_WIDTH (WIDTH edges).
- Throughput: one operation per WIDTH cycles. start asserted in the done cycle is accepted (back-to-back allowed).
- start while busy: ignored. Latched operands do not change, and the request is not queued.
- dataA/dataB/signal may change freely after the accept edge.
- Arithmetic wraps modulo 2^WIDTH. No saturation.
- done and err never assert during RUN. err is 0 whenever done is 0.

Decomposition:
- Package alu_pkg holds:
  - function-code localparams (FN_AND=6'd36, FN_OR=6'd37, FN_ADD=6'd32, FN_SUB=6'd34, FN_SLT=6'd42);
  - state encoding (ST_IDLE, ST_RUN);
  - an is_legal_fn function.
- One sub-module, alu_serial_slice: combinational 1-bit AND/OR/add/sub cell.
  - Inputs: a, b, cin, sub, fn. Outputs: out, cout.
  - Instantiated once.
- Counter, carry and result registers live in alu_serial_ctrl.

Test Plan:
- Reset, then ADD A=5, B=7 -> done exactly 32 cycles after accept; result=12, cout=0, ovf=0, zero=0, err=0.
- SUB A=3, B=5 -> result=32'hFFFFFFFE, cout=0. SUB A=9, B=9 -> result=0, zero=1, cout=1.
- SLT signed cases:
  - A=32'hFFFFFFFF, B=1 -> result=1.
  - A=32'h7FFFFFFF, B=32'h80000000 -> result=0, ovf=1 (overflow-corrected).
- AND/OR with A=32'hF0F0_1234, B=32'h0FF0_FF00:
  - AND -> result=32'h00F0_1200;
  - OR -> result=32'hFFF0_FF34;
  - cout=0 and ovf=0 in both cases.
- Illegal code signal=6'd0 with start -> done=1, err=1 on the next cycle, busy never 1. Then start ADD 1+1 in the done cycle -> accepted, result=2.
- Control edge cases:
  - start re-pulsed with different operands at cycle 10 of RUN -> ignored; original result is produced.
  - rst_n=0 at cycle 15 of RUN -> busy=0, done never pulses, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: function codes, FSM state encoding and legality check for the serial ALU
package alu_pkg;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_SLT = 6'd42;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic logic is_legal_fn(input logic [5:0] f);
    return f inside {FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT};
  endfunction
  function automatic logic is_sub_fn(input logic [5:0] f);
    return f == FN_SUB || f == FN_SLT;
  endfunction
endpackage

// File: rtl/alu_serial_slice.sv
// alu_serial_slice: combinational 1-bit AND/OR/add/sub cell
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       sub,
  input  logic [5:0] fn,
  output logic       out,
  output logic       cout
);
  logic bx;
  always_comb begin
    bx   = b ^ sub;
    out  = fn == FN_AND ? a & bx : fn == FN_OR ? a | bx : a ^ bx ^ cin;
    cout = (a & bx) | (a & cin) | (bx & cin);
  end
endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer, one slice reused LSB first over WIDTH clocks
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  state_t st_q, st_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, res_fin;
  logic [5:0] fn_q;
  logic [IDX_W-1:0] idx_q;
  logic carry_q, s_out, s_cout, last, arith, ovf_w, accept;
  logic done_q, err_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] result_q;
  alu_serial_slice u_slice (
    .a(a_q[idx_q]), .b(b_q[idx_q]), .cin(carry_q), .sub(is_sub_fn(fn_q)),
    .fn(fn_q), .out(s_out), .cout(s_cout)
  );
  // At the MSB edge carry_q is the carry into the MSB, so overflow needs no extra register
  always_comb begin
    accept = st_q == ST_IDLE && start && is_legal_fn(signal);
    last   = st_q == ST_RUN && idx_q == IDX_W'(WIDTH - 1);
    st_d   = accept ? ST_RUN : last ? ST_IDLE : st_q;
    arith  = fn_q != FN_AND && fn_q != FN_OR;
    ovf_w  = carry_q ^ s_cout;
    acc_d  = acc_q;
    acc_d[idx_q] = s_out;
    res_fin = fn_q == FN_SLT ? {{(WIDTH-1){1'b0}}, s_out ^ ovf_w} : acc_d;
  end
  always_ff @(posedge clk) st_q <= !rst_n ? ST_IDLE : st_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      fn_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        a_q     <= dataA;
        b_q     <= dataB;
        fn_q    <= signal;
        idx_q   <= '0;
        acc_q   <= '0;
        carry_q <= is_sub_fn(signal);
      end else if (st_q == ST_IDLE && start) begin
        done_q   <= 1'b1;
        err_q    <= 1'b1;
        result_q <= '0;
        zero_q   <= 1'b1;
        cout_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else if (st_q == ST_RUN) begin
        acc_q   <= acc_d;
        carry_q <= s_cout;
        idx_q   <= idx_q + IDX_W'(1);
        if (last) begin
          done_q   <= 1'b1;
          result_q <= res_fin;
          cout_q   <= arith & s_cout;
          ovf_q    <= arith & ovf_w;
          zero_q   <= res_fin == '0;
        end
      end
    end
  end
  assign busy   = st_q == ST_RUN;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed vectors with a queue scoreboard checked whenever done pulses
module tb_alu_serial_ctrl;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] res;
    logic cout, ovf, zero, err;
    int cyc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [5:0] signal = '0;
  logic [W-1:0] dataA = '0, dataB = '0;
  logic busy, done, err, cout, ovf, zero;
  logic [W-1:0] result;
  int cyc = 0, n_vec = 0, n_fail = 0;
  exp_t q[$];
  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signal(signal), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .err(err), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_vec++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_done: got done at cycle %0d, required no done", cyc);
      end else begin
        e = q.pop_front();
        if (result !== e.res || cout !== e.cout || ovf !== e.ovf || zero !== e.zero ||
            err !== e.err || cyc != e.cyc || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL op_result: got res=%h c=%b v=%b z=%b e=%b cyc=%0d busy=%b, required res=%h c=%b v=%b z=%b e=%b cyc=%0d busy=0",
                   result, cout, ovf, zero, err, cyc, busy, e.res, e.cout, e.ovf, e.zero, e.err, e.cyc);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [5:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] r, input logic c, input logic v,
                       input logic e);
    exp_t x;
    start = 1'b1;
    signal = s;
    dataA = a;
    dataB = b;
    x.res = r; x.cout = c; x.ovf = v; x.zero = (r == '0); x.err = e;
    x.cyc = cyc + (e ? 1 : W + 1);
    if (push) q.push_back(x);
    @(posedge clk);
    #1 start = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    signal = 6'd33;
  endtask
  task automatic wait_done();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 100);
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", k);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_err", W'(err), '0);
    chk("rst_result", result, '0);
    chk("rst_zero", W'(zero), W'(1));
    chk("rst_cout_ovf", W'({cout, ovf}), '0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(6'd32, 32'd5, 32'd7, 1, 32'd12, 0, 0, 0);                 wait_done();
    issue(6'd34, 32'd3, 32'd5, 1, 32'hFFFFFFFE, 0, 0, 0);           wait_done();
    issue(6'd34, 32'd9, 32'd9, 1, 32'd0, 1, 0, 0);                  wait_done();
    issue(6'd42, 32'hFFFFFFFF, 32'd1, 1, 32'd1, 1, 0, 0);           wait_done();
    issue(6'd42, 32'h7FFFFFFF, 32'h80000000, 1, 32'd0, 0, 1, 0);    wait_done();
    issue(6'd36, 32'hF0F01234, 32'h0FF0FF00, 1, 32'h00F01200, 0, 0, 0); wait_done();
    issue(6'd37, 32'hF0F01234, 32'h0FF0FF00, 1, 32'hFFF0FF34, 0, 0, 0); wait_done();
    issue(6'd32, 32'hFFFFFFFF, 32'd1, 1, 32'd0, 1, 0, 0);           wait_done();
    issue(6'd32, 32'h7FFFFFFF, 32'd1, 1, 32'h80000000, 0, 1, 0);    wait_done();
    issue(6'd0, 32'd4, 32'd4, 1, 32'd0, 0, 0, 1);
    chk("illegal_busy", W'(busy), '0);
    wait_done();
    chk("illegal_busy_done", W'(busy), '0);
    issue(6'd32, 32'd1, 32'd1, 1, 32'd2, 0, 0, 0);                  wait_done();
    issue(6'd32, 32'd100, 32'd23, 1, 32'd123, 0, 0, 0);
    repeat (9) @(negedge clk);
    chk("run_busy", W'(busy), W'(1));
    start = 1'b1;
    signal = 6'd34;
    dataA = 32'd1;
    dataB = 32'd50;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    @(negedge clk);
    issue(6'd32, 32'd5, 32'd5, 0, 32'd10, 0, 0, 0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_result", result, '0);
    chk("abort_zero", W'(zero), W'(1));
    repeat (40) @(negedge clk);
    chk("abort_idle", W'({busy, done}), '0);
    chk("queue_empty", W'(q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
